// File: rtl/pic_host_sequencer.sv
// ---------------------------------------------------------------------------
// pic_host_sequencer
//
// Host-side bus initiator for the 8259-style interrupt controller.
//  * On start_init it writes ICW1..ICW4 over WR_n/A0/data_out. ICW3 and ICW4
//    are skipped according to icw1_cfg[1] (single mode) and icw1_cfg[0]
//    (ICW4 needed).
//  * Once initialised, an INT request in IDLE starts the two-pulse INTA_n
//    acknowledge. The vector on data_in is captured at the end of the
//    second pulse.
//
// Optional feature macro: AUTO_EOI_WRITE_EN. When defined, every acknowledge
// is followed by a non-specific EOI write (OCW2 = 0x20, A0 = 0).
//
// Parameters
//   PULSE_CYCLES  low width of every WR_n / INTA_n pulse in clk cycles (>=1)
//   GAP_CYCLES    high time after every pulse in clk cycles (>=1)
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   start_init                 request to run the ICW sequence
//   icw1_cfg..icw4_cfg         ICW values, latched when start_init is accepted
//   INT                        interrupt request from the controller
//   data_in                    controller data bus, read during INTA
//   data_out, data_oe, A0      write data, bus drive enable, address line
//   WR_n, INTA_n               active-low write and acknowledge strobes
//   vector, vector_valid       last captured vector and its one-cycle pulse
//   busy, init_done            sequence in progress, initialisation complete
// ---------------------------------------------------------------------------
module pic_host_sequencer #(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_init,
    input  logic [7:0] icw1_cfg,
    input  logic [7:0] icw2_cfg,
    input  logic [7:0] icw3_cfg,
    input  logic [7:0] icw4_cfg,
    input  logic       INT,
    input  logic [7:0] data_in,
    output logic [7:0] data_out,
    output logic       data_oe,
    output logic       A0,
    output logic       WR_n,
    output logic       INTA_n,
    output logic [7:0] vector,
    output logic       vector_valid,
    output logic       busy,
    output logic       init_done
);

    localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CW         = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CW-1:0] PULSE_LAST = CW'(PULSE_CYCLES - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ZERO   = CW'(0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);
`ifdef AUTO_EOI_WRITE_EN
    localparam logic [7:0] OCW2_EOI = 8'h20;
`endif

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_W_SETUP  = 4'd1,
        ST_W_LOW    = 4'd2,
        ST_W_GAP    = 4'd3,
        ST_ACK1_LOW = 4'd4,
        ST_ACK_GAP  = 4'd5,
        ST_ACK2_LOW = 4'd6,
        ST_ACK2_GAP = 4'd7
`ifdef AUTO_EOI_WRITE_EN
        ,
        ST_E_SETUP  = 4'd8,
        ST_E_LOW    = 4'd9,
        ST_E_GAP    = 4'd10
`endif
    } state_t;

    state_t        state_r;
    state_t        state_next_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;
    logic [1:0]    idx_r;
    logic [1:0]    idx_next_s;
    logic [7:0]    icw1_r;
    logic [7:0]    icw2_r;
    logic [7:0]    icw3_r;
    logic [7:0]    icw4_r;
    logic          init_done_r;

    logic          accept_init_s;
    logic          last_write_s;
    logic          capture_s;
    logic [2:0]    slot_s;
    logic [7:0]    icw_dout_s;
    logic          icw_a0_s;
    logic          wr_n_s;
    logic          inta_n_s;
    logic          oe_s;
    logic [7:0]    dout_s;
    logic          a0_s;

    // Slot that follows ICW index idx. Bit 2 set means the list is finished;
    // ICW3 is skipped in single mode (ICW1 bit1) and ICW4 when ICW1 bit0 is 0.
    function automatic logic [2:0] next_slot(input logic [1:0] idx, input logic [7:0] icw1);
        logic [2:0] r;
        r = 3'b100;
        case (idx)
            2'd0: r = 3'b001;
            2'd1: begin
                if (!icw1[1]) begin
                    r = 3'b010;
                end else if (icw1[0]) begin
                    r = 3'b011;
                end else begin
                    r = 3'b100;
                end
            end
            2'd2: begin
                if (icw1[0]) begin
                    r = 3'b011;
                end else begin
                    r = 3'b100;
                end
            end
            default: r = 3'b100;
        endcase
        return r;
    endfunction

    // Write data for a latched ICW slot; ICW1 always carries bit4 = 1.
    function automatic logic [7:0] slot_data(input logic [1:0] idx, input logic [7:0] i1,
                                             input logic [7:0] i2, input logic [7:0] i3,
                                             input logic [7:0] i4);
        logic [7:0] d;
        case (idx)
            2'd0:    d = i1 | 8'h10;
            2'd1:    d = i2;
            2'd2:    d = i3;
            default: d = i4;
        endcase
        return d;
    endfunction

    // Next-state logic: phase sequencing, per-phase cycle counter and ICW index.
    always_comb begin
        state_next_s  = state_r;
        cnt_next_s    = cnt_r;
        idx_next_s    = idx_r;
        accept_init_s = 1'b0;
        last_write_s  = 1'b0;
        capture_s     = 1'b0;
        slot_s        = next_slot(idx_r, icw1_r);
        case (state_r)
            ST_IDLE: begin
                // start_init has priority over INT; INT needs a completed init
                if (start_init) begin
                    accept_init_s = 1'b1;
                    state_next_s  = ST_W_SETUP;
                    idx_next_s    = 2'd0;
                    cnt_next_s    = CNT_ZERO;
                end else if (init_done_r && INT) begin
                    state_next_s = ST_ACK1_LOW;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_W_SETUP: begin
                state_next_s = ST_W_LOW;
                cnt_next_s   = CNT_ZERO;
            end
            ST_W_LOW: begin
                if (cnt_r == PULSE_LAST) begin
                    state_next_s = ST_W_GAP;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            ST_W_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_next_s = CNT_ZERO;
                    if (slot_s[2]) begin
                        state_next_s = ST_IDLE;
                        last_write_s = 1'b1;
                    end else begin
                        state_next_s = ST_W_SETUP;
                        idx_next_s   = slot_s[1:0];
                    end
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            ST_ACK1_LOW: begin
                if (cnt_r == PULSE_LAST) begin
                    state_next_s = ST_ACK_GAP;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            ST_ACK_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_next_s = ST_ACK2_LOW;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            ST_ACK2_LOW: begin
                if (cnt_r == PULSE_LAST) begin
                    state_next_s = ST_ACK2_GAP;
                    cnt_next_s   = CNT_ZERO;
                    capture_s    = 1'b1;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            ST_ACK2_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    cnt_next_s = CNT_ZERO;
`ifdef AUTO_EOI_WRITE_EN
                    state_next_s = ST_E_SETUP;
`else
                    state_next_s = ST_IDLE;
`endif
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
`ifdef AUTO_EOI_WRITE_EN
            ST_E_SETUP: begin
                state_next_s = ST_E_LOW;
                cnt_next_s   = CNT_ZERO;
            end
            ST_E_LOW: begin
                if (cnt_r == PULSE_LAST) begin
                    state_next_s = ST_E_GAP;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
            ST_E_GAP: begin
                if (cnt_r == GAP_LAST) begin
                    state_next_s = ST_IDLE;
                    cnt_next_s   = CNT_ZERO;
                end else begin
                    cnt_next_s = cnt_r + CNT_ONE;
                end
            end
`endif
            default: begin
                state_next_s = ST_IDLE;
                cnt_next_s   = CNT_ZERO;
                idx_next_s   = 2'd0;
            end
        endcase
    end

    // ICW bus value for the upcoming cycle. On acceptance the cfg latches are
    // not loaded yet, so ICW1 comes straight from the input.
    always_comb begin
        if (accept_init_s) begin
            icw_dout_s = icw1_cfg | 8'h10;
            icw_a0_s   = 1'b0;
        end else begin
            icw_dout_s = slot_data(idx_next_s, icw1_r, icw2_r, icw3_r, icw4_r);
            icw_a0_s   = (idx_next_s != 2'd0);
        end
    end

    // Pin values decoded from the next state so the registered pins line up with it.
    always_comb begin
        wr_n_s   = 1'b1;
        inta_n_s = 1'b1;
        oe_s     = 1'b0;
        dout_s   = 8'h00;
        a0_s     = 1'b0;
        case (state_next_s)
            ST_W_SETUP, ST_W_GAP: begin
                oe_s   = 1'b1;
                dout_s = icw_dout_s;
                a0_s   = icw_a0_s;
            end
            ST_W_LOW: begin
                oe_s   = 1'b1;
                dout_s = icw_dout_s;
                a0_s   = icw_a0_s;
                wr_n_s = 1'b0;
            end
            ST_ACK1_LOW, ST_ACK2_LOW: begin
                inta_n_s = 1'b0;
            end
`ifdef AUTO_EOI_WRITE_EN
            ST_E_SETUP, ST_E_GAP: begin
                oe_s   = 1'b1;
                dout_s = OCW2_EOI;
            end
            ST_E_LOW: begin
                oe_s   = 1'b1;
                dout_s = OCW2_EOI;
                wr_n_s = 1'b0;
            end
`endif
            default: begin
                wr_n_s = 1'b1;
            end
        endcase
    end

    // Sequencer state, phase counter, ICW index and latched configuration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            cnt_r   <= CNT_ZERO;
            idx_r   <= 2'd0;
            icw1_r  <= 8'h00;
            icw2_r  <= 8'h00;
            icw3_r  <= 8'h00;
            icw4_r  <= 8'h00;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
            idx_r   <= idx_next_s;
            if (accept_init_s) begin
                icw1_r <= icw1_cfg;
                icw2_r <= icw2_cfg;
                icw3_r <= icw3_cfg;
                icw4_r <= icw4_cfg;
            end
        end
    end

    // Registered bus pins, status flags and captured vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            WR_n         <= 1'b1;
            INTA_n       <= 1'b1;
            A0           <= 1'b0;
            data_out     <= 8'h00;
            data_oe      <= 1'b0;
            vector       <= 8'h00;
            vector_valid <= 1'b0;
            busy         <= 1'b0;
            init_done_r  <= 1'b0;
        end else begin
            WR_n         <= wr_n_s;
            INTA_n       <= inta_n_s;
            A0           <= a0_s;
            data_out     <= dout_s;
            data_oe      <= oe_s;
            busy         <= (state_next_s != ST_IDLE);
            vector_valid <= capture_s;
            if (capture_s) begin
                vector <= data_in;
            end
            // A re-init withdraws init_done until its own last write ends
            if (accept_init_s) begin
                init_done_r <= 1'b0;
            end else if (last_write_s) begin
                init_done_r <= 1'b1;
            end
        end
    end

    assign init_done = init_done_r;

endmodule
